// File: rtl/debounce_bank.sv
// debounce_bank: NCH independent switch debouncers sampled on chatterclock.
// Each channel counts consecutive low (pressed) samples and consecutive
// high samples while pressed, producing a debounced press state, one-cycle
// press/release strobes and a toggle- or level-mode enable.
// Optional long-press strobe is built when DEBOUNCE_BANK_LONGPRESS_EN is defined.
module debounce_bank #(
    parameter int NCH    = 4,
    parameter int CW     = 8,
    parameter int THRESH = 5,
    parameter int LONG   = 200
) (
    input  logic              chatterclock,
    input  logic              reset,
    input  logic [NCH-1:0]    switchin,
    input  logic [NCH-1:0]    mode,
    output logic [NCH-1:0]    ispressed,
    output logic [NCH-1:0]    enabled,
    output logic [NCH-1:0]    press_pulse,
    output logic [NCH-1:0]    release_pulse,
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
    output logic [NCH-1:0]    long_pulse,
`endif
    output logic [NCH*CW-1:0] count
);

    localparam logic [CW-1:0] CMAX = '1;
    localparam logic [CW-1:0] TH   = CW'(THRESH);

    // Reject parameter sets outside the legal ranges at elaboration.
    if (NCH < 1 || NCH > 16 || THRESH < 1 || THRESH >= (1 << CW) ||
        LONG <= THRESH || LONG >= (1 << CW)) begin : g_bad_cfg
        $error("debounce_bank: illegal parameter combination");
    end

    logic [NCH-1:0][CW-1:0] count_q, count_d;
    logic [NCH-1:0][CW-1:0] rcnt_q, rcnt_d;
    logic [NCH-1:0]         pressed_q, pressed_d;
    logic [NCH-1:0]         en_q, en_d;
    logic [NCH-1:0]         ppulse_q, ppulse_d;
    logic [NCH-1:0]         rpulse_q, rpulse_d;

    // Per-channel counters, press/release detection and enable update.
    always_comb begin
        count_d   = '0;
        rcnt_d    = '0;
        pressed_d = pressed_q;
        en_d      = en_q;
        ppulse_d  = '0;
        rpulse_d  = '0;
        for (int i = 0; i < NCH; i++) begin
            // Low sample extends the press run; high sample breaks it.
            if (!switchin[i])
                count_d[i] = (count_q[i] == CMAX) ? CMAX : count_q[i] + 1'b1;
            // Release run only accumulates while the key is debounced-pressed.
            if (switchin[i] && pressed_q[i])
                rcnt_d[i] = (rcnt_q[i] == CMAX) ? CMAX : rcnt_q[i] + 1'b1;
            // Press needs a low sample and release a high one, so the two
            // strobes are mutually exclusive on a channel.
            if (!pressed_q[i] && count_d[i] == TH) begin
                pressed_d[i] = 1'b1;
                ppulse_d[i]  = 1'b1;
            end else if (pressed_q[i] && rcnt_d[i] == TH) begin
                pressed_d[i] = 1'b0;
                rpulse_d[i]  = 1'b1;
            end
            // Mode is looked at every edge, so a switch never forces a toggle.
            en_d[i] = mode[i] ? pressed_q[i] : (en_q[i] ^ ppulse_q[i]);
        end
    end

    // State registers, cleared asynchronously by reset.
    always_ff @(posedge chatterclock or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            rcnt_q    <= '0;
            pressed_q <= '0;
            en_q      <= '0;
            ppulse_q  <= '0;
            rpulse_q  <= '0;
        end else begin
            count_q   <= count_d;
            rcnt_q    <= rcnt_d;
            pressed_q <= pressed_d;
            en_q      <= en_d;
            ppulse_q  <= ppulse_d;
            rpulse_q  <= rpulse_d;
        end
    end

`ifdef DEBOUNCE_BANK_LONGPRESS_EN
    localparam logic [CW-1:0] LG = CW'(LONG);

    logic [NCH-1:0] lpulse_q, lpulse_d;

    // Long press fires when the run first reaches LONG; the count_q guard
    // keeps it single-shot even when LONG equals the saturation value.
    always_comb begin
        lpulse_d = '0;
        for (int i = 0; i < NCH; i++)
            lpulse_d[i] = (count_d[i] == LG) && (count_q[i] != LG);
    end

    // Long-press strobe register.
    always_ff @(posedge chatterclock or posedge reset) begin
        if (reset) lpulse_q <= '0;
        else       lpulse_q <= lpulse_d;
    end

    assign long_pulse = lpulse_q;
`endif

    assign ispressed     = pressed_q;
    assign enabled       = en_q;
    assign press_pulse   = ppulse_q;
    assign release_pulse = rpulse_q;
    assign count         = count_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: a vector table for the basic press /
// glitch sequences, plus hand-written sequences for toggle/level enable,
// saturation (CW=4 instance), async reset and the optional long press.
module tb_debounce_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  swa, modea, swb, modeb;
    logic [3:0]  ip_a, en_a, pp_a, rp_a, ip_b, en_b, pp_b, rp_b;
    logic [31:0] cnt_a;
    logic [15:0] cnt_b;
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
    logic [3:0]  lp_a, lp_b;
`endif

    always #5 clk = ~clk;

    debounce_bank #(.NCH(4), .CW(8), .THRESH(5), .LONG(20)) dut_a (
        .chatterclock(clk), .reset(rst), .switchin(swa), .mode(modea),
        .ispressed(ip_a), .enabled(en_a), .press_pulse(pp_a),
        .release_pulse(rp_a),
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
        .long_pulse(lp_a),
`endif
        .count(cnt_a));

    debounce_bank #(.NCH(4), .CW(4), .THRESH(5), .LONG(12)) dut_b (
        .chatterclock(clk), .reset(rst), .switchin(swb), .mode(modeb),
        .ispressed(ip_b), .enabled(en_b), .press_pulse(pp_b),
        .release_pulse(rp_b),
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
        .long_pulse(lp_b),
`endif
        .count(cnt_b));

    typedef struct {
        logic [3:0]  sw;
        logic [3:0]  ip, pp, rp, en;
        logic [31:0] cnt;
    } vec_t;

    vec_t vt[$];
    int   npass = 0;
    int   ntot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [3:0] sw, input logic [3:0] ip,
                                input logic [3:0] pp, input logic [3:0] rp,
                                input logic [3:0] en, input logic [31:0] cnt);
        vec_t v;
        v.sw = sw; v.ip = ip; v.pp = pp; v.rp = rp; v.en = en; v.cnt = cnt;
        vt.push_back(v);
    endfunction

    initial begin
        int npp, nrp, nlp, lp_edge;

        // ch0 held low 10 edges: count 1..10, press on edge 5, enable on 6.
        for (int k = 1; k <= 10; k++)
            add(4'hE, {3'b0, k >= 5}, {3'b0, k == 5}, 4'h0, {3'b0, k >= 6}, 32'(k));
        // ch0 released: release strobe on the 5th high sample.
        for (int r = 1; r <= 5; r++)
            add(4'hF, {3'b0, r < 5}, 4'h0, {3'b0, r == 5}, 4'h1, 32'h0);
        // ch1 glitchy burst: 4 low, 1 high, 4 low, never presses.
        for (int k = 1; k <= 4; k++) add(4'hD, 4'h0, 4'h0, 4'h0, 4'h1, 32'(k) << 8);
        add(4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 32'h0);
        for (int k = 1; k <= 4; k++) add(4'hD, 4'h0, 4'h0, 4'h0, 4'h1, 32'(k) << 8);
        add(4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 32'h0);

        rst = 1'b1; swa = 4'hF; modea = 4'h0; swb = 4'hF; modeb = 4'h0;
        tick(); tick();
        #2 rst = 1'b0;
        chk("reset_ip", {28'b0, ip_a}, 32'h0);
        chk("reset_en", {28'b0, en_a}, 32'h0);
        chk("reset_cnt", cnt_a, 32'h0);

        foreach (vt[n]) begin
            swa = vt[n].sw;
            tick();
            chk($sformatf("vec%0d_ip", n), {28'b0, ip_a}, {28'b0, vt[n].ip});
            chk($sformatf("vec%0d_pp", n), {28'b0, pp_a}, {28'b0, vt[n].pp});
            chk($sformatf("vec%0d_rp", n), {28'b0, rp_a}, {28'b0, vt[n].rp});
            chk($sformatf("vec%0d_en", n), {28'b0, en_a}, {28'b0, vt[n].en});
            chk($sformatf("vec%0d_cnt", n), cnt_a, vt[n].cnt);
        end

        // ch2 toggle mode: two presses -> enabled2 0->1->0, one edge after each pulse.
        for (int p = 0; p < 2; p++) begin
            swa = 4'hB;
            for (int k = 1; k <= 5; k++) tick();
            chk("tog_pp2", {31'b0, pp_a[2]}, 32'h1);
            chk("tog_en2_at_pulse", {31'b0, en_a[2]}, (p == 0) ? 32'h0 : 32'h1);
            tick();
            chk("tog_en2_after", {31'b0, en_a[2]}, (p == 0) ? 32'h1 : 32'h0);
            chk("tog_pp2_onecycle", {31'b0, pp_a[2]}, 32'h0);
            swa = 4'hF;
            for (int r = 1; r <= 5; r++) tick();
            chk("tog_rel_ip2", {31'b0, ip_a[2]}, 32'h0);
        end

        // ch3 level mode, then switch modes with no spurious toggle.
        modea = 4'h8; swa = 4'h7;
        for (int k = 1; k <= 5; k++) tick();
        chk("lvl_ip3", {31'b0, ip_a[3]}, 32'h1);
        chk("lvl_en3_lag", {31'b0, en_a[3]}, 32'h0);
        tick();
        chk("lvl_en3", {31'b0, en_a[3]}, 32'h1);
        modea = 4'h0;
        for (int k = 1; k <= 3; k++) tick();
        chk("mode_sw_en3_hold", {31'b0, en_a[3]}, 32'h1);
        swa = 4'hF;
        for (int r = 1; r <= 5; r++) tick();
        chk("mode_sw_ip3_rel", {31'b0, ip_a[3]}, 32'h0);
        chk("mode_sw_en3_toggle_keep", {31'b0, en_a[3]}, 32'h1);
        modea = 4'h8;
        tick();
        chk("mode_back_lvl_en3", {31'b0, en_a[3]}, 32'h0);
        modea = 4'h0;

        // CW=4 instance: ch3 held 30 edges saturates at 15, one press strobe.
        swb = 4'h7; npp = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (pp_b[3]) npp++;
            if (k == 15) chk("sat_cnt3_at15", {28'b0, cnt_b[15:12]}, 32'hF);
        end
        chk("sat_cnt3", {28'b0, cnt_b[15:12]}, 32'hF);
        chk("sat_pp3_once", npp, 1);
        chk("sat_ip3", {31'b0, ip_b[3]}, 32'h1);
        swb = 4'hF; nrp = 0;
        for (int r = 1; r <= 5; r++) begin
            tick();
            if (rp_b[3]) nrp++;
            if (r == 5) chk("sat_rp3_edge5", {31'b0, rp_b[3]}, 32'h1);
        end
        chk("sat_rp3_once", nrp, 1);
        chk("sat_ip3_rel", {31'b0, ip_b[3]}, 32'h0);

        // Async reset mid-cycle at count0=3 discards the press.
        swa = 4'hE;
        for (int k = 1; k <= 3; k++) tick();
        chk("rst_pre_cnt0", cnt_a, 32'h3);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_cnt", cnt_a, 32'h0);
        chk("rst_async_ip", {28'b0, ip_a}, 32'h0);
        chk("rst_async_en", {28'b0, en_a}, 32'h0);
        chk("rst_async_pp", {28'b0, pp_a | rp_a}, 32'h0);
        tick();
        #2 rst = 1'b0;
        npp = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (pp_a[0]) npp++;
            chk($sformatf("rst_after_pp0_e%0d", k), {31'b0, pp_a[0]}, (k == 5) ? 32'h1 : 32'h0);
        end
        chk("rst_after_cnt0", cnt_a, 32'h5);

`ifdef DEBOUNCE_BANK_LONGPRESS_EN
        // ch0 held 40 edges: exactly one long strobe, on edge 20.
        #2 rst = 1'b1;
        #1;
        chk("long_rst", {28'b0, lp_a}, 32'h0);
        #2 rst = 1'b0;
        nlp = 0; lp_edge = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (lp_a[0]) begin nlp++; lp_edge = k; end
        end
        chk("long_once", nlp, 1);
        chk("long_edge", lp_edge, 20);
`else
        nlp = 0; lp_edge = 0;
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
